mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side end of the shared accelerator memory bus (sel / w_en / address_bus / bidirectional
//  data_bus / ready). Serves single-word read/write requests from a layer engine with a fixed
//  LATENCY and a one-cycle ready pulse. Backed by an internal word RAM, with a host preload port so
//  benches and the top level can load activations, weights and biases without hierarchical writes.
// PARAMETERS
//  DATA_WIDTH     32   bus/word width in bits
//  ADDRESS_WIDTH  8    address_bus width
//  DEPTH          256  implemented words; addresses >= DEPTH are out of range
//  LATENCY        1    cycles from request capture to ready (legal range 1..15)
// PORTS
//  clk          in     1              clock, all logic on posedge
//  rst          in     1              synchronous reset, active-high
//  sel          in     1              initiator request strobe
//  w_en         in     1              1 = write, 0 = read; sampled with sel
//  address_bus  in     ADDRESS_WIDTH  word address; sampled with sel
//  data_bus     inout  DATA_WIDTH     write data in (sampled with sel); read data out while ready=1
//  ready        out    1              one-cycle completion pulse
//  err          out    1              pulses with ready when the captured address >= DEPTH
//  busy         out    1              1 whenever state != IDLE
//  host_we      in     1              host preload write strobe
//  host_addr    in     ADDRESS_WIDTH  host preload address
//  host_wdata   in     DATA_WIDTH     host preload data
//  host_drop    out    1              one-cycle pulse: host write rejected
// BEHAVIOUR
//  - Reset (synchronous, wins over everything): state=IDLE; ready=0, err=0, busy=0, host_drop=0;
//    data_bus released (Z). RAM contents are not cleared.
//  - FSM states: IDLE, WAIT, RESP, HOLD.
//    IDLE: at an edge with sel=1, capture address_bus, w_en and data_bus into internal registers;
//          load the counter with LATENCY-1. Go to RESP if LATENCY=1, otherwise go to WAIT.
//    WAIT: decrement the counter each edge. Go to RESP at the edge where the counter is 1.
//          Changes to sel, address_bus or data_bus during WAIT are ignored.
//    RESP: ready=1 for exactly this one cycle.
//          Capture happens at edge t; ready is high in the cycle that follows edge t+LATENCY.
//          Write request: the RAM word is committed at the edge that enters RESP.
//          Read request: data_bus is driven with RAM[addr] only while in RESP; Z otherwise.
//          Leaving RESP: go to IDLE if sel=0 at the leaving edge, otherwise go to HOLD.
//    HOLD: wait for sel=0, then go to IDLE. Every request therefore needs sel low for at least one
//          sampled edge; a sel held high is never served twice.
//  - Out of range (captured addr >= DEPTH): same timing as a normal request and err=1 with ready.
//    A read drives all-zero data. A write is discarded and the RAM is left unchanged.
//  - Host port: host_we is accepted only when state=IDLE and sel=0 at that edge; RAM[host_addr] is
//    written at that edge. An out-of-range host_addr is dropped silently.
//    host_we while busy=1 or sel=1 is not written; host_drop=1 in the next cycle instead.
//    The bus request always wins a same-edge collision.
//  - Reset mid-request: the request is aborted. No write is committed unless the commit edge
//    preceded reset, no ready pulse occurs, and data_bus is released immediately.
//  - Only one request is outstanding at a time. There is no byte masking; full words only.
// TESTING
//  1 Preload via host: RAM[0..3]=1,2,3,4. Read addr 2 with LATENCY=1: sel at edge t ->
//    ready=1 and data_bus=3 in the cycle after edge t+1; ready=0 and data_bus=Z one cycle later.
//  2 LATENCY=4: write 0xDEADBEEF to addr 32, then read addr 32 -> ready exactly 4 cycles after
//    capture each time; the read returns 0xDEADBEEF.
//  3 Initiator holds sel=1 for 6 cycles after ready -> exactly one ready pulse; the next request is
//    served only after sel drops for one edge.
//  4 DEPTH=64: read addr 100 -> ready=1, err=1, data_bus=0. Write addr 100 -> err=1, and a follow-up
//    host readback of addr 36 (100 mod 64) shows no change.
//  5 host_we on the same edge as a bus capture, and again while busy -> both dropped with a
//    host_drop pulse each; RAM unchanged at host_addr.
//  6 Assert rst during WAIT of a write to addr 5 (old value 7) -> no ready pulse, data_bus=Z, and a
//    post-reset read of addr 5 returns 7.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
// Memory-side end of the shared accelerator memory bus. Accepts one single-word
// read or write request at a time from a layer engine, answers after a fixed
// LATENCY with a one-cycle ready pulse (err alongside for out-of-range
// addresses), and offers a host preload port into the same word RAM.
//
// Timing: a request captured at edge t is committed (writes) at the edge that
// enters RESP, and ready/err/read data are registered out of RESP so they are
// visible in the cycle that follows edge t+LATENCY.

module mem_bus_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256,
  parameter int LATENCY       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic                     w_en,
  input  logic [ADDRESS_WIDTH-1:0] address_bus,
  inout  wire  [DATA_WIDTH-1:0]    data_bus,
  output logic                     ready,
  output logic                     err,
  output logic                     busy,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic                     host_drop
);

  // RAM index width; addresses are range-checked before this slice is used.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH at the width of a zero-extended address, for the range compare.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);

  // Counter preload at capture; the counter runs down to 1 in WAIT.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  // FSM state and request capture registers
  state_t                   r_state;
  logic [3:0]               r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_we;
  logic [DATA_WIDTH-1:0]    r_wdata;

  // Registered outputs
  logic                     r_ready;
  logic                     r_err;
  logic                     r_busy;
  logic                     r_host_drop;
  logic                     r_drive;
  logic [DATA_WIDTH-1:0]    r_rdata;

  // Word storage
  logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];

  // Combinational helpers
  logic                     w_cap_in_range;
  logic                     w_host_wr;
  logic                     w_host_drop;
  logic                     w_commit;
  logic [IDX_W-1:0]         w_commit_idx;
  logic [DATA_WIDTH-1:0]    w_commit_data;

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  assign w_cap_in_range = in_range(r_addr);

  // Host writes only land when the bus is fully quiet; the bus always wins.
  assign w_host_wr   = host_we && (r_state == S_IDLE) && !sel && in_range(host_addr);
  assign w_host_drop = host_we && ((r_state != S_IDLE) || sel);

  // Select the write that commits at the edge entering RESP (if any).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_commit      = 1'b0;
    w_commit_idx  = '0;
    w_commit_data = '0;
    if ((r_state == S_IDLE) && sel && (LATENCY == 1)) begin
      // Single-cycle latency: the capture edge is also the commit edge.
      w_commit      = w_en && in_range(address_bus);
      w_commit_idx  = address_bus[IDX_W-1:0];
      w_commit_data = data_bus;
    end else if ((r_state == S_WAIT) && (r_cnt == 4'd1)) begin
      w_commit      = r_we && w_cap_in_range;
      w_commit_idx  = r_addr[IDX_W-1:0];
      w_commit_data = r_wdata;
    end
  end

  // Request sequencing FSM with registered ready/err/busy/host_drop and read data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_host_drop <= 1'b0;
      r_drive     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_host_drop <= w_host_drop;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_drive     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sel) begin
            r_addr  <= address_bus;
            r_we    <= w_en;
            r_wdata <= data_bus;
            r_cnt   <= CNT_INIT;
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_err   <= !w_cap_in_range;
          r_drive <= !r_we;
          r_rdata <= (r_we || !w_cap_in_range) ? '0 : r_mem[r_addr[IDX_W-1:0]];
          if (sel) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!sel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port shared by host preload and bus commits (mutually exclusive by state/sel).
  // NOTE: the RAM array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_host_wr) begin
        r_mem[host_addr[IDX_W-1:0]] <= host_wdata;
      end else if (w_commit) begin
        r_mem[w_commit_idx] <= w_commit_data;
      end
    end
  end

  assign data_bus  = r_drive ? r_rdata : {DATA_WIDTH{1'bz}};
  assign ready     = r_ready;
  assign err       = r_err;
  assign busy      = r_busy;
  assign host_drop = r_host_drop;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder. Two instances: u_lat1 (DEPTH=256, LATENCY=1)
// and u_d64 (DEPTH=64, LATENCY=4). A released bus is detected by driving a
// zero probe from the bench side and reading zero back.

module tb_mem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        sel       [2];
  logic        w_en      [2];
  logic [7:0]  addr      [2];
  logic        ready     [2];
  logic        err       [2];
  logic        busy      [2];
  logic        host_we   [2];
  logic [7:0]  host_addr [2];
  logic [31:0] host_wd   [2];
  logic        host_drop [2];
  logic [31:0] drv       [2];
  logic        oe        [2];

  wire  [31:0] bus0;
  wire  [31:0] bus1;
  assign bus0 = oe[0] ? drv[0] : 32'hzzzz_zzzz;
  assign bus1 = oe[1] ? drv[1] : 32'hzzzz_zzzz;

  mem_bus_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .DEPTH(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .sel(sel[0]), .w_en(w_en[0]), .address_bus(addr[0]),
    .data_bus(bus0), .ready(ready[0]), .err(err[0]), .busy(busy[0]),
    .host_we(host_we[0]), .host_addr(host_addr[0]), .host_wdata(host_wd[0]),
    .host_drop(host_drop[0])
  );

  mem_bus_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .DEPTH(64), .LATENCY(4)) u_d64 (
    .clk(clk), .rst(rst[1]), .sel(sel[1]), .w_en(w_en[1]), .address_bus(addr[1]),
    .data_bus(bus1), .ready(ready[1]), .err(err[1]), .busy(busy[1]),
    .host_we(host_we[1]), .host_addr(host_addr[1]), .host_wdata(host_wd[1]),
    .host_drop(host_drop[1])
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          dut;
    logic        we;
    logic [7:0]  a;
    logic [31:0] wd;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus must be released: a bench-driven zero probe must read back as zero.
  task automatic check_released(input int d, input string name);
    drv[d] = 32'h0;
    oe[d]  = 1'b1;
    #1;
    check({name, " released"}, bus_of(d), 32'h0);
    oe[d]  = 1'b0;
  endtask

  task automatic host_write(input int d, input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    host_we[d]   = 1'b1;
    host_addr[d] = a;
    host_wd[d]   = v;
    @(negedge clk);
    host_we[d]   = 1'b0;
  endtask

  // One bus request: sel high for exactly the capture edge, then inputs scrambled.
  task automatic run_req(input int d, input logic we, input logic [7:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                         input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    sel[d]  = 1'b1;
    w_en[d] = we;
    addr[d] = a;
    drv[d]  = wd;
    oe[d]   = we;
    @(posedge clk);
    @(negedge clk);
    sel[d]  = 1'b0;
    oe[d]   = 1'b0;
    w_en[d] = ~we;
    addr[d] = ~a;
    drv[d]  = ~wd;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ready[d]) begin
        lat = n;
        break;
      end
      check({name, " busy"}, 32'(busy[d]), 32'd1);
    end
    check({name, " latency"}, lat, exp_lat);
    if (lat != 0) begin
      check({name, " err"}, 32'(err[d]), 32'(exp_err));
      if (!we) check({name, " rdata"}, bus_of(d), exp_rd);
      @(posedge clk);
      #1;
      check({name, " ready low"}, 32'(ready[d]), 32'd0);
      check({name, " err low"}, 32'(err[d]), 32'd0);
      check_released(d, name);
    end
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{0, 1'b0, 8'd2,   32'h0,         1, 1'b0, 32'd3,         "t1_rd2"};
    vecs[1]  = '{0, 1'b0, 8'd0,   32'h0,         1, 1'b0, 32'd1,         "rd0"};
    vecs[2]  = '{0, 1'b1, 8'd10,  32'hA5A5_0001, 1, 1'b0, 32'h0,         "wr10"};
    vecs[3]  = '{0, 1'b0, 8'd10,  32'h0,         1, 1'b0, 32'hA5A5_0001, "rd10"};
    vecs[4]  = '{0, 1'b1, 8'd255, 32'h1234_5678, 1, 1'b0, 32'h0,         "wr255"};
    vecs[5]  = '{0, 1'b0, 8'd255, 32'h0,         1, 1'b0, 32'h1234_5678, "rd255"};
    vecs[6]  = '{1, 1'b1, 8'd32,  32'hDEAD_BEEF, 4, 1'b0, 32'h0,         "t2_wr32"};
    vecs[7]  = '{1, 1'b0, 8'd32,  32'h0,         4, 1'b0, 32'hDEAD_BEEF, "t2_rd32"};
    vecs[8]  = '{1, 1'b0, 8'd100, 32'h0,         4, 1'b1, 32'h0,         "t4_rd100"};
    vecs[9]  = '{1, 1'b1, 8'd100, 32'hCAFE_F00D, 4, 1'b1, 32'h0,         "t4_wr100"};
    vecs[10] = '{1, 1'b0, 8'd36,  32'h0,         4, 1'b0, 32'h1111_1111, "t4_rd36"};
    vecs[11] = '{1, 1'b1, 8'd63,  32'h0BAD_F00D, 4, 1'b0, 32'h0,         "wr63"};
    vecs[12] = '{1, 1'b0, 8'd63,  32'h0,         4, 1'b0, 32'h0BAD_F00D, "rd63"};
    vecs[13] = '{1, 1'b0, 8'd64,  32'h0,         4, 1'b1, 32'h0,         "rd64"};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; w_en[d] = 1'b0; addr[d] = 8'h0;
      host_we[d] = 1'b0; host_addr[d] = 8'h0; host_wd[d] = 32'h0;
      drv[d] = 32'h0; oe[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst ready", 32'(ready[d]), 32'd0);
      check("rst err", 32'(err[d]), 32'd0);
      check("rst busy", 32'(busy[d]), 32'd0);
      check("rst host_drop", 32'(host_drop[d]), 32'd0);
      check_released(d, "rst");
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Preload through the host port
    for (int i = 0; i < 4; i++) host_write(0, 8'(i), 32'(i + 1));
    host_write(1, 8'd36, 32'h1111_1111);
    host_write(1, 8'd5,  32'd7);
    #1;
    check("host accepted no drop", 32'(host_drop[1]), 32'd0);

    // Table-driven requests
    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i].dut, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].exp_lat,
              vecs[i].exp_err, vecs[i].exp_rd, vecs[i].name);
    end

    // sel held high: one ready pulse only, then served again after sel drops
    @(negedge clk);
    sel[0] = 1'b1; w_en[0] = 1'b0; addr[0] = 8'd1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ready[0]) pulses++;
    end
    check("t3 single pulse", pulses, 32'd1);
    check("t3 hold busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    sel[0] = 1'b0; addr[0] = 8'hEE;
    @(posedge clk);
    #1;
    check("t3 idle after drop", 32'(busy[0]), 32'd0);
    run_req(0, 1'b0, 8'd3, 32'h0, 1, 1'b0, 32'd4, "t3_rd3");

    // host_we colliding with a capture, then while busy
    @(negedge clk);
    sel[0] = 1'b1; w_en[0] = 1'b0; addr[0] = 8'd0;
    host_we[0] = 1'b1; host_addr[0] = 8'd0; host_wd[0] = 32'h99;
    @(posedge clk);
    #1;
    check("t5 collision drop", 32'(host_drop[0]), 32'd1);
    check("t5 busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    sel[0] = 1'b0; host_addr[0] = 8'd1; host_wd[0] = 32'h77;
    @(posedge clk);
    #1;
    check("t5 busy drop", 32'(host_drop[0]), 32'd1);
    check("t5 ready", 32'(ready[0]), 32'd1);
    check("t5 rd0 unchanged", bus0, 32'd1);
    @(negedge clk);
    host_we[0] = 1'b0;
    @(posedge clk);
    #1;
    check("t5 drop one cycle", 32'(host_drop[0]), 32'd0);
    run_req(0, 1'b0, 8'd0, 32'h0, 1, 1'b0, 32'd1, "t5_rd0");
    run_req(0, 1'b0, 8'd1, 32'h0, 1, 1'b0, 32'd2, "t5_rd1");

    // Reset during WAIT of a write to addr 5 (old value 7)
    @(negedge clk);
    sel[1] = 1'b1; w_en[1] = 1'b1; addr[1] = 8'd5; drv[1] = 32'h55; oe[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sel[1] = 1'b0; oe[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    check("t6 busy cleared", 32'(busy[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ready[1]) pulses++;
    end
    check("t6 no ready", pulses, 32'd0);
    check_released(1, "t6");
    run_req(1, 1'b0, 8'd5, 32'h0, 4, 1'b0, 32'd7, "t6_rd5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
